bcd_to_bin_seq: RTL and testbench

- Sequential BCD-to-binary converter using reverse double dabble: shift right by one bit, then subtract 3 from any digit >= 8.
- Inverse of the team's binary-to-BCD combinational converter. Used by the FPGA wrapper to turn packed BCD digits (e.g. keypad/switch entry) back to binary.
- Processes one bit per clock. Ready/valid handshake on both input and output sides.

---
 rtl/bcd_to_bin_seq.sv | 134 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_seq
// Purpose  : Sequential BCD-to-binary converter (reverse double dabble).
//            One bit per clock, ready/valid handshake on input and output.
//            Optional macro BCD2BIN_ERR_EN enables invalid-digit detection.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   in_bcd,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIN_W-1:0]      out_bin,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // One iteration: shift {bcd, bin} right, then correct each digit >= 8.
  logic [BCD_W+BIN_W-1:0] w_shift;
  logic [BCD_W-1:0]       w_bcd_sh;
  logic [BIN_W-1:0]       w_bin_sh;
  logic [BCD_W-1:0]       w_bcd_adj;

  assign w_shift  = {bcd_q, bin_q} >> 1;
  assign w_bcd_sh = w_shift[BCD_W+BIN_W-1:BIN_W];
  assign w_bin_sh = w_shift[BIN_W-1:0];

  // A digit >= 8 always has bit 3 set, so no borrow crosses digit boundaries.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign w_bcd_adj[4*g +: 4] = w_bcd_sh[4*g+3] ? (w_bcd_sh[4*g +: 4] - 4'd3)
                                                 : w_bcd_sh[4*g +: 4];
  end

`ifdef BCD2BIN_ERR_EN
  logic              err_q, err_d;
  logic [DIGITS-1:0] w_dig_bad;

  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    assign w_dig_bad[g] = (in_bcd[4*g +: 4] > 4'd9);
  end

  // Error flag register, only present when digit checking is built in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign out_err = err_q && (state_q == ST_DONE);
  assign out_bin = (state_q == ST_DONE && !err_q) ? bin_q : '0;
`else
  assign out_err = 1'b0;
  assign out_bin = (state_q == ST_DONE) ? bin_q : '0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef BCD2BIN_ERR_EN
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bcd_d   = in_bcd;
          bin_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = ST_SHIFT;
`ifdef BCD2BIN_ERR_EN
          err_d   = |w_dig_bad;
`endif
        end
      end
      ST_SHIFT: begin
        bcd_d = w_bcd_adj;
        bin_d = w_bin_sh;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
`ifdef BCD2BIN_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin_seq
// Purpose  : Self-checking bench for bcd_to_bin_seq with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [11:0]       in_bcd;
  logic              in_valid;
  logic              in_ready;
  logic [BIN_W-1:0]  out_bin;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_acc = -1;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_bcd(in_bcd), .in_valid(in_valid),
    .in_ready(in_ready), .out_bin(out_bin), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Algorithm reference: plain integer form of reverse double dabble.
  function automatic int raw_algo(input int w);
    int b = 0;
    int v = w;
    for (int it = 0; it < BIN_W; it++) begin
      b = (b >> 1) | ((v & 1) << (BIN_W - 1));
      v = v >> 1;
      for (int d = 0; d < DIGITS; d++)
        if (((v >> (4*d)) & 15) >= 8) v = v - (3 << (4*d));
    end
    return b;
  endfunction

  // Expected result: decimal value for valid words, algorithm output otherwise.
  task automatic expect_of(input int w, output int eb, output int ee);
    int dec = 0;
    int bad = 0;
    for (int d = DIGITS-1; d >= 0; d--) begin
      dec = dec * 10 + ((w >> (4*d)) & 15);
      if (((w >> (4*d)) & 15) > 9) bad = 1;
    end
`ifdef BCD2BIN_ERR_EN
    ee = bad;
    eb = bad ? 0 : dec;
`else
    ee = 0;
    eb = bad ? raw_algo(w) : dec;
`endif
  endtask

  task automatic convert(input int w, input int hold, input bit noisy, input bit gap_chk);
    int eb, ee, lat;
    expect_of(w, eb, ee);
    chk("in_ready_idle", in_ready, 1);
    in_bcd   = w[11:0];
    in_valid = 1'b1;
    step();
    if (gap_chk && last_acc >= 0) chk("accept_gap", cyc - last_acc, BIN_W + 2);
    last_acc = cyc;
    in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    in_bcd   = 12'($urandom);
    chk("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, BIN_W);
    chk("out_bin", out_bin, eb);
    chk("out_err", out_err, ee);
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        step();
        chk("hold_valid", out_valid, 1);
        chk("hold_bin", out_bin, eb);
        chk("hold_ready", in_ready, 0);
      end
    end
    out_ready = 1'b1;
    step();
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
  endtask

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_out_err", out_err, 0);
    rst_n = 1'b1;
    step();

    convert('h999, 0, 0, 0);
    convert('h255, 5, 0, 0);
    convert('h000, 0, 0, 0);
    convert('h010, 0, 0, 0);
    convert('hA05, 0, 0, 0);
    convert('h105, 0, 0, 0);

    // Reset in the middle of a conversion.
    in_bcd = 12'h999; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_bin", out_bin, 0);
    chk("mid_rst_err", out_err, 0);
    repeat (12) begin
      step();
      chk("mid_rst_no_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    step();
    convert('h042, 0, 0, 0);

    // Exhaustive back-to-back sweep of valid words.
    last_acc = -1;
    for (int v = 0; v < 1000; v++) begin
      w = ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
      convert(w, 0, 0, 1);
    end

    // Randomised words including invalid digits, stalls and idle gaps.
    for (int n = 0; n < 300; n++) begin
      w = 0;
      for (int d = 0; d < DIGITS; d++)
        w = w | (($urandom_range(0, 7) == 0 ? int'($urandom_range(10, 15))
                                            : int'($urandom_range(0, 9))) << (4*d));
      convert(w, int'($urandom_range(0, 3)), 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
